// File: rtl/axi4lite_led_pattern_master.sv
// axi4lite_led_pattern_master
//   Standalone AXI4-Lite master for board bring-up. On every programmable tick
//   it writes the next LED pattern to the slave's LED register, reads it back,
//   compares, and keeps sticky status flags plus a saturating error counter.
//
// Ports
//   m_axi_aclk, m_axi_areset    clock, asynchronous active-high reset
//   enable                      tick generation / launch enable
//   mode[1:0]                   00 rotl, 01 increment, 10 invert, 11 sw_pattern
//   sw_pattern                  pattern used in mode 11
//   clear_status                pulse: clear sticky flags and err_count
//   m_axi_aw*/w*/b*/ar*/r*      AXI4-Lite master channels
//   busy                        transaction in progress
//   pattern                     current pattern register
//   mismatch, resp_err, overrun sticky status flags
//   err_count                   saturating mismatch + response error count
module axi4lite_led_pattern_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LED_WIDTH  = 8,
  parameter int unsigned TICK_DIV   = 50000000,
  parameter logic [ADDR_WIDTH-1:0] LED_ADDR = '0
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_areset,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic [LED_WIDTH-1:0]    sw_pattern,
  input  logic                    clear_status,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic                    busy,
  output logic [LED_WIDTH-1:0]    pattern,
  output logic                    mismatch,
  output logic                    resp_err,
  output logic                    overrun,
  output logic [7:0]              err_count
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    READ_ADDR,
    READ_DATA
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]     tick_cnt;
  logic                 tick;
  logic                 pending;
  logic                 launch;
  logic                 ovr_evt;
  logic [1:0]           mode_q;
  logic [LED_WIDTH-1:0] launch_val;
  logic [LED_WIDTH-1:0] written;
  logic [LED_WIDTH-1:0] next_pattern;
  logic                 b_hs, r_hs;
  logic                 b_err, r_err, r_mis;
  logic [1:0]           err_inc;
  logic [8:0]           err_sum;
  logic                 unused_rdata;

  // Address and strobes never change, so they are trivially stable under valid.
  assign m_axi_awaddr = LED_ADDR;
  assign m_axi_araddr = LED_ADDR;
  assign m_axi_wstrb  = '1;

  assign m_axi_bready  = (state == WRESP);
  assign m_axi_arvalid = (state == READ_ADDR);
  assign m_axi_rready  = (state == READ_DATA);
  assign busy          = (state != IDLE);

  assign tick       = enable && (tick_cnt == TICK_LAST);
  assign launch     = (state == IDLE) && pending && enable;
  // A tick coinciding with a launch refills the slot being consumed, not an overrun.
  assign ovr_evt    = tick && pending && !launch;
  assign launch_val = (mode == 2'b11) ? sw_pattern : pattern;
  assign written    = m_axi_wdata[LED_WIDTH-1:0];

  assign b_hs  = (state == WRESP) && m_axi_bvalid;
  assign r_hs  = (state == READ_DATA) && m_axi_rvalid;
  assign b_err = b_hs && (m_axi_bresp != 2'b00);
  assign r_err = r_hs && (m_axi_rresp != 2'b00);
  assign r_mis = r_hs && (m_axi_rdata[LED_WIDTH-1:0] != written);

  assign err_inc = {1'b0, b_err} + {1'b0, r_err} + {1'b0, r_mis};
  assign err_sum = {1'b0, err_count} + {7'b0, err_inc};

  assign unused_rdata = ^m_axi_rdata;

  // Next pattern derives from the value actually written, using the mode
  // captured at launch.
  always_comb begin
    next_pattern = written;
    unique case (mode_q)
      2'b00:   next_pattern = (written << 1) | (written >> (LED_WIDTH - 1));
      2'b01:   next_pattern = written + 1'b1;
      2'b10:   next_pattern = ~written;
      default: next_pattern = written;
    endcase
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (launch) state_next = WRITE;
      WRITE:     if ((!m_axi_awvalid || m_axi_awready) &&
                     (!m_axi_wvalid  || m_axi_wready)) state_next = WRESP;
      WRESP:     if (m_axi_bvalid) state_next = READ_ADDR;
      READ_ADDR: if (m_axi_arready) state_next = READ_DATA;
      READ_DATA: if (m_axi_rvalid) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) state <= IDLE;
    else              state <= state_next;
  end

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      tick_cnt <= '0;
      pending  <= 1'b0;
    end else begin
      if (!enable || tick) tick_cnt <= '0;
      else                 tick_cnt <= tick_cnt + 1'b1;

      if (!enable)     pending <= 1'b0;
      else if (tick)   pending <= 1'b1;
      else if (launch) pending <= 1'b0;
    end
  end

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= '0;
      mode_q        <= 2'b00;
      pattern       <= LED_WIDTH'(1);
    end else begin
      if (launch) begin
        m_axi_awvalid <= 1'b1;
        m_axi_wvalid  <= 1'b1;
        m_axi_wdata   <= DATA_WIDTH'(launch_val);
        mode_q        <= mode;
      end else if (state == WRITE) begin
        // Each valid falls independently after its own handshake.
        m_axi_awvalid <= m_axi_awvalid && !m_axi_awready;
        m_axi_wvalid  <= m_axi_wvalid && !m_axi_wready;
      end
      if (r_hs) pattern <= next_pattern;
    end
  end

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      mismatch  <= 1'b0;
      resp_err  <= 1'b0;
      overrun   <= 1'b0;
      err_count <= '0;
    end else if (clear_status) begin
      mismatch  <= r_mis;
      resp_err  <= b_err || r_err;
      overrun   <= ovr_evt;
      err_count <= {6'b0, err_inc};
    end else begin
      mismatch  <= mismatch || r_mis;
      resp_err  <= resp_err || b_err || r_err;
      overrun   <= overrun || ovr_evt;
      err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end

endmodule

// File: tb/tb_axi4lite_led_pattern_master.sv
`timescale 1ns/1ps
// tb_axi4lite_led_pattern_master
//   Directed bench for axi4lite_led_pattern_master with a behavioural
//   AXI4-Lite slave holding one LED register (configurable stalls/responses).
module tb_axi4lite_led_pattern_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  sw_pattern = 8'h00;
  logic        clear_status = 1'b0;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic        busy, mismatch, resp_err, overrun;
  logic [7:0]  pattern, err_count;

  int vectors = 0;
  int miscompares = 0;

  // slave configuration
  int          aw_delay = 0;
  int          w_delay = 0;
  int          b_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic        rd_ovr_en = 1'b0;
  logic [7:0]  rd_ovr = 8'h00;

  // slave state
  int          aw_cnt, w_cnt, b_cnt;
  logic        got_aw, got_w;
  logic [7:0]  led_reg;
  int          n_aw, n_w, n_b;
  logic [7:0]  wlog[$];

  always #5 clk = ~clk;

  axi4lite_led_pattern_master #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .LED_WIDTH (8),
    .TICK_DIV  (4),
    .LED_ADDR  (32'h0000_0010)
  ) dut (
    .m_axi_aclk   (clk),
    .m_axi_areset (rst),
    .enable       (enable),
    .mode         (mode),
    .sw_pattern   (sw_pattern),
    .clear_status (clear_status),
    .m_axi_awaddr (awaddr),
    .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata  (wdata),
    .m_axi_wstrb  (wstrb),
    .m_axi_wvalid (wvalid),
    .m_axi_wready (wready),
    .m_axi_bresp  (bresp),
    .m_axi_bvalid (bvalid),
    .m_axi_bready (bready),
    .m_axi_araddr (araddr),
    .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rdata  (rdata),
    .m_axi_rresp  (rresp),
    .m_axi_rvalid (rvalid),
    .m_axi_rready (rready),
    .busy         (busy),
    .pattern      (pattern),
    .mismatch     (mismatch),
    .resp_err     (resp_err),
    .overrun      (overrun),
    .err_count    (err_count)
  );

  assign awready = awvalid && (aw_cnt >= aw_delay);
  assign wready  = wvalid && (w_cnt >= w_delay);
  assign arready = arvalid;
  assign bresp   = bresp_cfg;
  assign rresp   = 2'b00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      got_aw <= 1'b0; got_w <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; rdata <= '0;
      led_reg <= 8'h00;
    end else begin
      if (awvalid && !awready) aw_cnt <= aw_cnt + 1; else aw_cnt <= 0;
      if (wvalid && !wready)   w_cnt  <= w_cnt + 1;  else w_cnt  <= 0;
      if (got_aw && got_w && !bvalid) begin
        if (b_cnt >= b_delay) begin
          bvalid <= 1'b1; got_aw <= 1'b0; got_w <= 1'b0; b_cnt <= 0;
        end else b_cnt <= b_cnt + 1;
      end
      if (awvalid && awready) begin got_aw <= 1'b1; n_aw <= n_aw + 1; end
      if (wvalid && wready) begin
        got_w <= 1'b1; led_reg <= wdata[7:0]; n_w <= n_w + 1;
        wlog.push_back(wdata[7:0]);
      end
      if (bvalid && bready) begin bvalid <= 1'b0; n_b <= n_b + 1; end
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= {24'h0, rd_ovr_en ? rd_ovr : led_reg};
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  initial begin n_aw = 0; n_w = 0; n_b = 0; end

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 100) begin @(negedge clk); guard++; end
    vectors++;
    if (busy) begin
      miscompares++;
      $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, guard);
    end
  endtask

  task automatic run_writes(input int n);
    int target = wlog.size() + n;
    int guard = 0;
    enable = 1'b1;
    while (wlog.size() < target && guard < n * 30 + 60) begin @(negedge clk); guard++; end
    enable = 1'b0;
    vectors++;
    if (wlog.size() < target) begin
      miscompares++;
      $display("FAIL run_writes: got %0d writes, required %0d", wlog.size(), target);
    end
    wait_idle();
  endtask

  task automatic pulse_clear();
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
      miscompares++; $display("FAIL reset_valids: got %b expected 00000", {awvalid, wvalid, bready, arvalid, rready}); end
    vectors++; if (awaddr !== 32'h10 || araddr !== 32'h10) begin
      miscompares++; $display("FAIL reset_addr: got aw=%h ar=%h expected 00000010", awaddr, araddr); end
    vectors++; if (wdata !== 32'h0 || wstrb !== 4'hF) begin
      miscompares++; $display("FAIL reset_wdata: got wdata=%h wstrb=%h expected 0/f", wdata, wstrb); end
    vectors++; if (pattern !== 8'h01 || busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_pattern: got pattern=%h busy=%b expected 01/0", pattern, busy); end
    vectors++; if ({mismatch, resp_err, overrun} !== 3'b0 || err_count !== 8'h00) begin
      miscompares++; $display("FAIL reset_status: got flags=%b cnt=%0d expected 000/0", {mismatch, resp_err, overrun}, err_count); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rotate();
    logic [7:0] exp_w [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    wlog.delete();
    mode = 2'b00;
    run_writes(9);
    for (int i = 0; i < 9; i++) begin
      vectors++; if (wlog[i] !== exp_w[i]) begin
        miscompares++; $display("FAIL rotate_write[%0d]: got %h expected %h", i, wlog[i], exp_w[i]); end
    end
    vectors++; if (pattern !== 8'h02 || mismatch !== 1'b0) begin
      miscompares++; $display("FAIL rotate_end: got pattern=%h mismatch=%b expected 02/0", pattern, mismatch); end
  endtask

  task automatic test_increment();
    logic [7:0] exp_w [3] = '{8'hFE, 8'hFF, 8'h00};
    mode = 2'b11; sw_pattern = 8'hFE;
    run_writes(1);
    vectors++; if (pattern !== 8'hFE) begin
      miscompares++; $display("FAIL inc_seed: got %h expected fe", pattern); end
    wlog.delete();
    mode = 2'b01;
    run_writes(3);
    for (int i = 0; i < 3; i++) begin
      vectors++; if (wlog[i] !== exp_w[i]) begin
        miscompares++; $display("FAIL inc_write[%0d]: got %h expected %h", i, wlog[i], exp_w[i]); end
    end
    vectors++; if (pattern !== 8'h01 || led_reg !== 8'h00 || mismatch !== 1'b0) begin
      miscompares++; $display("FAIL inc_end: got pattern=%h led=%h mismatch=%b expected 01/00/0", pattern, led_reg, mismatch); end
  endtask

  task automatic test_split_handshake();
    int a0 = n_aw, w0 = n_w, b0 = n_b;
    int guard = 0;
    aw_delay = 0; w_delay = 3;
    mode = 2'b11; sw_pattern = 8'h3C;
    enable = 1'b1;
    while (!awvalid && guard < 20) begin @(negedge clk); guard++; end
    enable = 1'b0;
    vectors++; if ({awvalid, awready, wvalid, wready} !== 4'b1110 || wdata !== 32'h3C) begin
      miscompares++; $display("FAIL split_c0: got aw/awr/w/wr=%b wdata=%h expected 1110/3c", {awvalid, awready, wvalid, wready}, wdata); end
    @(negedge clk);
    vectors++; if ({awvalid, wvalid} !== 2'b01) begin
      miscompares++; $display("FAIL split_c1: got aw/w=%b expected 01", {awvalid, wvalid}); end
    @(negedge clk);
    vectors++; if ({wvalid, wready} !== 2'b10) begin
      miscompares++; $display("FAIL split_c2: got w/wr=%b expected 10", {wvalid, wready}); end
    @(negedge clk);
    vectors++; if ({wvalid, wready} !== 2'b11) begin
      miscompares++; $display("FAIL split_c3: got w/wr=%b expected 11", {wvalid, wready}); end
    @(negedge clk);
    vectors++; if (wvalid !== 1'b0) begin
      miscompares++; $display("FAIL split_c4: got wvalid=%b expected 0", wvalid); end
    wait_idle();
    vectors++; if (n_aw - a0 != 1 || n_w - w0 != 1 || n_b - b0 != 1) begin
      miscompares++; $display("FAIL split_counts: got aw=%0d w=%0d b=%0d expected 1/1/1", n_aw - a0, n_w - w0, n_b - b0); end
    vectors++; if (led_reg !== 8'h3C || mismatch !== 1'b0) begin
      miscompares++; $display("FAIL split_data: got led=%h mismatch=%b expected 3c/0", led_reg, mismatch); end
    w_delay = 0;
  endtask

  task automatic test_errors();
    pulse_clear();
    bresp_cfg = 2'b10; rd_ovr_en = 1'b1; rd_ovr = 8'h55;
    mode = 2'b11; sw_pattern = 8'hAA;
    run_writes(1);
    vectors++; if ({mismatch, resp_err} !== 2'b11 || err_count !== 8'd2) begin
      miscompares++; $display("FAIL err_flags: got mis/resp=%b cnt=%0d expected 11/2", {mismatch, resp_err}, err_count); end
    run_writes(126);
    vectors++; if (err_count !== 8'd254) begin
      miscompares++; $display("FAIL err_count_254: got %0d expected 254", err_count); end
    run_writes(1);
    vectors++; if (err_count !== 8'd255) begin
      miscompares++; $display("FAIL err_count_sat: got %0d expected 255", err_count); end
    pulse_clear();
    vectors++; if ({mismatch, resp_err, overrun} !== 3'b0 || err_count !== 8'd0) begin
      miscompares++; $display("FAIL err_clear: got flags=%b cnt=%0d expected 000/0", {mismatch, resp_err, overrun}, err_count); end
    bresp_cfg = 2'b00; rd_ovr_en = 1'b0;
  endtask

  task automatic test_overrun();
    int a0 = n_aw, b0 = n_b;
    int guard = 0, idle = 0;
    vectors++; if (overrun !== 1'b0) begin
      miscompares++; $display("FAIL ovr_start: got %b expected 0", overrun); end
    b_delay = 10;
    mode = 2'b11; sw_pattern = 8'h5A;
    enable = 1'b1;
    while (!(bvalid && bready) && guard < 60) begin @(negedge clk); guard++; end
    b_delay = 0;
    vectors++; if (overrun !== 1'b1 || n_aw - a0 != 1) begin
      miscompares++; $display("FAIL ovr_stall: got overrun=%b launches=%0d expected 1/1", overrun, n_aw - a0); end
    guard = 0;
    while (!awvalid && guard < 30) begin
      if (!busy) idle++;
      @(negedge clk); guard++;
    end
    enable = 1'b0;
    wait_idle();
    vectors++; if (idle != 1) begin
      miscompares++; $display("FAIL ovr_relaunch_gap: got %0d idle cycles expected 1", idle); end
    vectors++; if (n_aw - a0 != 2 || n_b - b0 != 2 || led_reg !== 8'h5A) begin
      miscompares++; $display("FAIL ovr_counts: got aw=%0d b=%0d led=%h expected 2/2/5a", n_aw - a0, n_b - b0, led_reg); end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    mode = 2'b00;
    enable = 1'b1;
    while (!arvalid && guard < 40) begin @(negedge clk); guard++; end
    vectors++; if (arvalid !== 1'b1 || pattern !== 8'h5A) begin
      miscompares++; $display("FAIL rmid_reach: got arvalid=%b pattern=%h expected 1/5a", arvalid, pattern); end
    rst = 1'b1;
    #1;
    vectors++; if ({arvalid, awvalid, wvalid, busy} !== 4'b0 || pattern !== 8'h01) begin
      miscompares++; $display("FAIL rmid_reset: got ar/aw/w/busy=%b pattern=%h expected 0000/01", {arvalid, awvalid, wvalid, busy}, pattern); end
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wlog.delete();
    run_writes(1);
    vectors++; if (wlog.size() < 1 || wlog[0] !== 8'h01) begin
      miscompares++; $display("FAIL rmid_first_write: got %h expected 01", (wlog.size() > 0) ? wlog[0] : 8'hxx); end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_increment();
    test_split_handshake();
    test_errors();
    test_overrun();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
